mem_stall_bridge: RTL and testbench

MEM_STALL_BRIDGE -- requirements
Module: mem_stall_bridge

---
 rtl/mem_stall_bridge.sv | 198 +++++++++++++++++++
 tb/tb_mem_stall_bridge.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_bridge.sv
// mem_stall_bridge
//   Bridges a stalling CPU with separate data and instruction ports onto a
//   single valid/ready memory request channel with a one-cycle completion
//   pulse. A data access is always issued before an instruction access
//   sampled on the same edge. The CPU is frozen through `stall` while any
//   access is outstanding.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   dcache_* (addr/we/re/din)     CPU data port request
//   icache_* (addr/we/re/din)     CPU instruction port request
//   dcache_dout, instruction      registered read results
//   stall                         CPU freeze, decoded from state only
//   mem_req_*                     memory request channel (valid/ready)
//   mem_resp_valid, mem_resp_data memory completion pulse and read data
module mem_stall_bridge #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] BOOT_DOUT = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dcache_addr,
    input  logic [3:0]        dcache_we,
    input  logic              dcache_re,
    input  logic [31:0]       dcache_din,
    input  logic [31:0]       icache_addr,
    input  logic [3:0]        icache_we,
    input  logic              icache_re,
    input  logic [31:0]       icache_din,
    output logic [31:0]       dcache_dout,
    output logic [31:0]       instruction,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_mask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    typedef enum logic [2:0] {
        StIdle,
        StDReq,
        StDWait,
        StIReq,
        StIWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Request fields currently presented on the memory channel.
    logic              req_rnw_q, req_rnw_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [3:0]        req_mask_q, req_mask_d;

    // Instruction access held back while the data access completes.
    logic              i_pend_q, i_pend_d;
    logic              i_rnw_q, i_rnw_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d;
    logic [31:0]       i_wdata_q, i_wdata_d;
    logic [3:0]        i_mask_q, i_mask_d;

    logic [31:0]       dout_q, dout_d;
    logic [31:0]       instr_q, instr_d;

    logic              d_req, i_req;
    logic              d_rnw, i_rnw;
    logic [3:0]        d_mask, i_mask;
    logic [ADDR_W-1:0] d_addr, i_addr;

    assign d_req  = dcache_re | (|dcache_we);
    assign i_req  = icache_re | (|icache_we);

    // Any nonzero byte enable makes the access a write, even with re high.
    assign d_rnw  = ~(|dcache_we);
    assign i_rnw  = ~(|icache_we);
    assign d_mask = d_rnw ? 4'hF : dcache_we;
    assign i_mask = i_rnw ? 4'hF : icache_we;
    assign d_addr = {dcache_addr[ADDR_W-1:2], 2'b00};
    assign i_addr = {icache_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        req_rnw_d   = req_rnw_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_mask_d  = req_mask_q;
        i_pend_d    = i_pend_q;
        i_rnw_d     = i_rnw_q;
        i_addr_d    = i_addr_q;
        i_wdata_d   = i_wdata_q;
        i_mask_d    = i_mask_q;
        dout_d      = dout_q;
        instr_d     = instr_q;

        unique case (state_q)
            StIdle, StResp: begin
                if (d_req) begin
                    state_d     = StDReq;
                    req_rnw_d   = d_rnw;
                    req_addr_d  = d_addr;
                    req_wdata_d = dcache_din;
                    req_mask_d  = d_mask;
                    i_pend_d    = i_req;
                    i_rnw_d     = i_rnw;
                    i_addr_d    = i_addr;
                    i_wdata_d   = icache_din;
                    i_mask_d    = i_mask;
                end else if (i_req) begin
                    state_d     = StIReq;
                    req_rnw_d   = i_rnw;
                    req_addr_d  = i_addr;
                    req_wdata_d = icache_din;
                    req_mask_d  = i_mask;
                    i_pend_d    = 1'b0;
                end else begin
                    state_d     = StIdle;
                    i_pend_d    = 1'b0;
                end
            end
            StDReq: begin
                if (mem_req_ready) state_d = StDWait;
            end
            StDWait: begin
                if (mem_resp_valid) begin
                    if (req_rnw_q) dout_d = mem_resp_data;
                    if (i_pend_q) begin
                        // Chain straight into the held instruction access.
                        state_d     = StIReq;
                        req_rnw_d   = i_rnw_q;
                        req_addr_d  = i_addr_q;
                        req_wdata_d = i_wdata_q;
                        req_mask_d  = i_mask_q;
                        i_pend_d    = 1'b0;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StIReq: begin
                if (mem_req_ready) state_d = StIWait;
            end
            StIWait: begin
                if (mem_resp_valid) begin
                    if (req_rnw_q) instr_d = mem_resp_data;
                    state_d = StResp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            req_rnw_q   <= 1'b1;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_mask_q  <= '0;
            i_pend_q    <= 1'b0;
            i_rnw_q     <= 1'b1;
            i_addr_q    <= '0;
            i_wdata_q   <= '0;
            i_mask_q    <= '0;
            dout_q      <= BOOT_DOUT;
            instr_q     <= BOOT_DOUT;
        end else begin
            state_q     <= state_d;
            req_rnw_q   <= req_rnw_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_mask_q  <= req_mask_d;
            i_pend_q    <= i_pend_d;
            i_rnw_q     <= i_rnw_d;
            i_addr_q    <= i_addr_d;
            i_wdata_q   <= i_wdata_d;
            i_mask_q    <= i_mask_d;
            dout_q      <= dout_d;
            instr_q     <= instr_d;
        end
    end

    // Outputs depend on registers only; no input reaches them combinationally.
    assign mem_req_valid = (state_q == StDReq) || (state_q == StIReq);
    assign stall         = (state_q == StDReq) || (state_q == StDWait) ||
                           (state_q == StIReq) || (state_q == StIWait);
    assign mem_req_rnw   = req_rnw_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_mask  = req_mask_q;
    assign dcache_dout   = dout_q;
    assign instruction   = instr_q;

endmodule

// File: tb/tb_mem_stall_bridge.sv
module tb_mem_stall_bridge;

    localparam int unsigned AW   = 24;
    localparam logic [31:0] BOOT = 32'hA5A5_0F0F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   dcache_addr = '0, dcache_din = '0, icache_addr = '0, icache_din = '0;
    logic [3:0]    dcache_we = '0, icache_we = '0;
    logic          dcache_re = 1'b0, icache_re = 1'b0;
    logic [31:0]   dcache_dout, instruction;
    logic          stall, mem_req_valid, mem_req_rnw;
    logic          mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic [31:0]   mem_req_wdata, mem_resp_data = '0;
    logic [3:0]    mem_req_mask;

    mem_stall_bridge #(.ADDR_W(AW), .BOOT_DOUT(BOOT)) dut (
        .clk           (clk),
        .rst           (rst),
        .dcache_addr   (dcache_addr),
        .dcache_we     (dcache_we),
        .dcache_re     (dcache_re),
        .dcache_din    (dcache_din),
        .icache_addr   (icache_addr),
        .icache_we     (icache_we),
        .icache_re     (icache_re),
        .icache_din    (icache_din),
        .dcache_dout   (dcache_dout),
        .instruction   (instruction),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rnw   (mem_req_rnw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_mask  (mem_req_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          port_d;
        logic          rnw;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    mask;
        logic [31:0]   rdata;
    } txn_t;

    typedef struct {
        logic        re_d;
        logic [3:0]  we_d;
        logic [31:0] a_d, w_d;
        logic        re_i;
        logic [3:0]  we_i;
        logic [31:0] a_i, w_i;
    } op_t;

    txn_t        obs_q[$];
    txn_t        exp_q[$];
    int          obs_stall, obs_valid_cyc, exp_stall;
    bit          obs_stable;
    bit          force_en = 1'b0;
    logic [31:0] force_data = '0;
    logic [31:0] exp_dout = BOOT, exp_instr = BOOT;

    function automatic logic [AW-1:0] waddr(input logic [31:0] a);
        logic [AW-1:0] r;
        r      = a[AW-1:0];
        r[1:0] = 2'b00;
        return r;
    endfunction

    // Reference: the transfers one CPU access should produce, data port first.
    function automatic void build_exp(input op_t op);
        txn_t t;
        exp_q.delete();
        if (op.re_d || op.we_d != 4'h0) begin
            t.port_d = 1'b1;
            t.rnw    = (op.we_d == 4'h0);
            t.addr   = waddr(op.a_d);
            t.wdata  = op.w_d;
            t.mask   = t.rnw ? 4'hF : op.we_d;
            t.rdata  = '0;
            exp_q.push_back(t);
        end
        if (op.re_i || op.we_i != 4'h0) begin
            t.port_d = 1'b0;
            t.rnw    = (op.we_i == 4'h0);
            t.addr   = waddr(op.a_i);
            t.wdata  = op.w_i;
            t.mask   = t.rnw ? 4'hF : op.we_i;
            t.rdata  = '0;
            exp_q.push_back(t);
        end
    endfunction

    // Drives one CPU access and plays the memory. Records what it saw; callers check.
    task automatic run_op(input op_t op, input int rmin, input int rmax,
                          input int wmin, input int wmax, input bit noise);
        int   k = 0, j = 0, rd = 0, wd = 0;
        bit   in_req = 1'b0, done = 1'b0;
        txn_t cur;
        obs_q.delete();
        obs_stall = 0; obs_valid_cyc = 0; obs_stable = 1'b1; exp_stall = 0;
        cur = '{default: '0};
        dcache_re = op.re_d; dcache_we = op.we_d; dcache_addr = op.a_d; dcache_din = op.w_d;
        icache_re = op.re_i; icache_we = op.we_i; icache_addr = op.a_i; icache_din = op.w_i;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = force_en ? force_data : $urandom;
            if (!stall) begin
                if (noise) begin
                    mem_req_ready  = 1'($urandom_range(1, 0));
                    mem_resp_valid = 1'($urandom_range(1, 0));
                end
                done = 1'b1;
                break;
            end
            obs_stall++;
            if (mem_req_valid) begin
                obs_valid_cyc++;
                if (!in_req) begin
                    in_req    = 1'b1;
                    k         = 0;
                    rd        = $urandom_range(rmax, rmin);
                    wd        = $urandom_range(wmax, wmin);
                    exp_stall += rd + wd + 2;
                    cur.rnw   = mem_req_rnw;
                    cur.addr  = mem_req_addr;
                    cur.wdata = mem_req_wdata;
                    cur.mask  = mem_req_mask;
                end else if (mem_req_rnw !== cur.rnw || mem_req_addr !== cur.addr ||
                             mem_req_wdata !== cur.wdata || mem_req_mask !== cur.mask) begin
                    obs_stable = 1'b0;
                end
                if (k >= rd) mem_req_ready = 1'b1;
                else if (noise) mem_resp_valid = 1'($urandom_range(1, 0));
                k++;
            end else begin
                if (in_req) begin
                    in_req = 1'b0;
                    j      = 0;
                end
                if (j >= wd) begin
                    mem_resp_valid = 1'b1;
                    cur.rdata      = mem_resp_data;
                    obs_q.push_back(cur);
                end else if (noise) begin
                    mem_req_ready = 1'($urandom_range(1, 0));
                end
                j++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: stall still %b after 300 cycles, required 0", stall);
        end
        dcache_re = 1'b0; dcache_we = '0; icache_re = 1'b0; icache_we = '0;
    endtask

    // Apply reference read results in issue order.
    function automatic void update_model();
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (exp_q[i].rnw) begin
                if (exp_q[i].port_d) exp_dout = obs_q[i].rdata;
                else exp_instr = obs_q[i].rdata;
            end
        end
    endfunction

    task automatic test_reset();
        n_checks++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall/valid %b%b, required 00", stall, mem_req_valid);
        end
        n_checks++;
        if (mem_req_rnw !== 1'b1 || mem_req_addr !== '0 || mem_req_wdata !== '0 ||
            mem_req_mask !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_fields: rnw %b addr %h wdata %h mask %h, required 1 0 0 0",
                     mem_req_rnw, mem_req_addr, mem_req_wdata, mem_req_mask);
        end
        n_checks++;
        if (dcache_dout !== BOOT || instruction !== BOOT) begin
            n_fail++;
            $display("FAIL reset_dout: dout %h instr %h, required %h", dcache_dout, instruction,
                     BOOT);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: stall %b, required 0", stall);
        end
    endtask

    task automatic test_fetch();
        op_t op = '{default: '0};
        op.re_i = 1'b1; op.a_i = 32'h0000_1006;
        force_en = 1'b1; force_data = 32'h2409_0005;
        run_op(op, 0, 0, 0, 0, 1'b0);
        force_en = 1'b0;
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0].addr !== 24'h001004 || obs_q[0].rnw !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_req: %0d reqs, first addr %h rnw %b, required 1 001004 1",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0].addr : '0,
                     obs_q.size() > 0 ? obs_q[0].rnw : 1'b0);
        end
        n_checks++;
        if (obs_stall != 2) begin
            n_fail++;
            $display("FAIL fetch_stall: %0d stall cycles, required 2", obs_stall);
        end
        n_checks++;
        if (instruction !== 32'h2409_0005) begin
            n_fail++;
            $display("FAIL fetch_data: instr %h, required 24090005", instruction);
        end
        exp_instr = 32'h2409_0005;
    endtask

    task automatic test_dual();
        op_t op = '{default: '0};
        op.we_d = 4'b0011; op.a_d = 32'h10; op.w_d = 32'hDEAD_BEEF;
        op.re_i = 1'b1; op.a_i = 32'h40;
        run_op(op, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL dual_count: %0d reqs, required 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0].rnw !== 1'b0 || obs_q[0].mask !== 4'b0011 ||
                obs_q[0].addr !== 24'h10 || obs_q[0].wdata !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL dual_write: rnw %b mask %h addr %h wdata %h, required 0 3 10 deadbeef",
                         obs_q[0].rnw, obs_q[0].mask, obs_q[0].addr, obs_q[0].wdata);
            end
            n_checks++;
            if (obs_q[1].rnw !== 1'b1 || obs_q[1].addr !== 24'h40 || obs_q[1].mask !== 4'hF) begin
                n_fail++;
                $display("FAIL dual_read: rnw %b addr %h mask %h, required 1 40 f",
                         obs_q[1].rnw, obs_q[1].addr, obs_q[1].mask);
            end
            exp_instr = obs_q[1].rdata;
        end
        n_checks++;
        if (obs_stall != 4) begin
            n_fail++;
            $display("FAIL dual_stall: %0d stall cycles, required 4", obs_stall);
        end
        n_checks++;
        if (dcache_dout !== exp_dout || instruction !== exp_instr) begin
            n_fail++;
            $display("FAIL dual_dout: dout %h instr %h, required %h %h", dcache_dout, instruction,
                     exp_dout, exp_instr);
        end
    endtask

    task automatic test_re_and_we();
        op_t op = '{default: '0};
        op.re_d = 1'b1; op.we_d = 4'hF; op.a_d = 32'h0000_0123; op.w_d = 32'h1234_5678;
        run_op(op, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0].rnw !== 1'b0 || obs_q[0].mask !== 4'hF ||
            obs_q[0].addr !== 24'h000120) begin
            n_fail++;
            $display("FAIL re_we_write: %0d reqs, first rnw %b mask %h, required 1 req 0 f",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0].rnw : 1'bx,
                     obs_q.size() > 0 ? obs_q[0].mask : 4'hx);
        end
        n_checks++;
        if (dcache_dout !== exp_dout) begin
            n_fail++;
            $display("FAIL re_we_dout: dout %h, required %h", dcache_dout, exp_dout);
        end
    endtask

    task automatic test_ready_hold();
        op_t op = '{default: '0};
        op.re_d = 1'b1; op.a_d = 32'h0000_0A08;
        run_op(op, 5, 5, 0, 0, 1'b0);
        n_checks++;
        if (obs_valid_cyc != 6 || !obs_stable) begin
            n_fail++;
            $display("FAIL hold_valid: valid %0d cycles stable %b, required 6 1",
                     obs_valid_cyc, obs_stable);
        end
        n_checks++;
        if (obs_stall != 7) begin
            n_fail++;
            $display("FAIL hold_stall: %0d stall cycles, required 7", obs_stall);
        end
        if (obs_q.size() > 0) exp_dout = obs_q[0].rdata;
        n_checks++;
        if (dcache_dout !== exp_dout) begin
            n_fail++;
            $display("FAIL hold_dout: dout %h, required %h", dcache_dout, exp_dout);
        end
    endtask

    task automatic test_reset_mid();
        icache_re = 1'b1; icache_addr = 32'h80;
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        n_checks++;
        if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait: stall/valid %b%b, required 10", stall, mem_req_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0 || instruction !== BOOT) begin
            n_fail++;
            $display("FAIL mid_async: stall %b valid %b instr %h, required 0 0 %h",
                     stall, mem_req_valid, instruction, BOOT);
        end
        icache_re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        exp_dout = BOOT; exp_instr = BOOT;
        n_checks++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0 || instruction !== BOOT) begin
            n_fail++;
            $display("FAIL mid_late_resp: stall %b valid %b instr %h, required 0 0 %h",
                     stall, mem_req_valid, instruction, BOOT);
        end
    endtask

    task automatic test_back_to_back();
        op_t op = '{default: '0};
        int  c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            op.re_d = 1'b1; op.a_d = 32'(4 * i);
            run_op(op, 0, 0, 0, 0, 1'b0);
            if (obs_q.size() > 0) exp_dout = obs_q[0].rdata;
            n_checks++;
            if (obs_stall != 2 || dcache_dout !== exp_dout) begin
                n_fail++;
                $display("FAIL b2b_%0d: stall %0d dout %h, required 2 %h", i, obs_stall,
                         dcache_dout, exp_dout);
            end
        end
        n_checks++;
        if (cyc - c0 != 9) begin
            n_fail++;
            $display("FAIL b2b_cycles: %0d cycles for 3 reads, required 9", cyc - c0);
        end
    endtask

    task automatic test_random();
        op_t op;
        for (int n = 0; n < 40; n++) begin
            op.re_d = 1'($urandom_range(1, 0));
            op.we_d = ($urandom_range(1, 0) != 0) ? 4'($urandom) : 4'h0;
            op.a_d  = $urandom; op.w_d = $urandom;
            op.re_i = 1'($urandom_range(1, 0));
            op.we_i = ($urandom_range(2, 0) == 0) ? 4'($urandom) : 4'h0;
            op.a_i  = $urandom; op.w_i = $urandom;
            build_exp(op);
            run_op(op, 0, 3, 0, 3, 1'b1);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rnd_count[%0d]: %0d reqs, required %0d", n, obs_q.size(),
                         exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (obs_q[i].rnw !== exp_q[i].rnw || obs_q[i].addr !== exp_q[i].addr ||
                        obs_q[i].mask !== exp_q[i].mask ||
                        (!exp_q[i].rnw && obs_q[i].wdata !== exp_q[i].wdata)) begin
                        n_fail++;
                        $display("FAIL rnd_req[%0d.%0d]: rnw %b addr %h mask %h wdata %h, required %b %h %h %h",
                                 n, i, obs_q[i].rnw, obs_q[i].addr, obs_q[i].mask,
                                 obs_q[i].wdata, exp_q[i].rnw, exp_q[i].addr,
                                 exp_q[i].mask, exp_q[i].wdata);
                    end
                end
            end
            n_checks++;
            if (obs_stall != exp_stall || !obs_stable) begin
                n_fail++;
                $display("FAIL rnd_stall[%0d]: %0d cycles stable %b, required %0d 1", n,
                         obs_stall, obs_stable, exp_stall);
            end
            update_model();
            n_checks++;
            if (dcache_dout !== exp_dout || instruction !== exp_instr) begin
                n_fail++;
                $display("FAIL rnd_dout[%0d]: dout %h instr %h, required %h %h", n,
                         dcache_dout, instruction, exp_dout, exp_instr);
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_fetch();
        test_dual();
        test_re_and_we();
        test_ready_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
